// File: rtl/execute_stage.sv
// Execute stage: RV32I ALU, RV32M multiply, and an iterative 32-step restoring divider.
// Latency: 1 cycle for ALU/MUL/special divides, 33 cycles for a normal divide/remainder.
// Backpressure: stall_in freezes the stage; stall_out = stall_in or divider busy.
module execute_stage (
  input  logic        clock,
  input  logic        reset,
  input  logic        valid_in,
  input  logic        stall_in,
  input  logic [2:0]  funct3,
  input  logic        alt,
  input  logic        m_ext,
  input  logic        use_imm,
  input  logic [31:0] imm,
  input  logic [31:0] rs1_value,
  input  logic [31:0] rs2_value,
  input  logic [4:0]  rd,
  input  logic        write_rd,
  output logic        stall_out,
  output logic        valid_out,
  output logic [31:0] result,
  output logic [4:0]  rd_out,
  output logic        write_rd_out
);

  typedef enum logic {IDLE, DIVIDE} state_t;
  state_t state, state_next;

  logic [31:0] operand_b;
  logic [4:0]  shamt;
  assign operand_b = use_imm ? imm : rs2_value;
  assign shamt     = operand_b[4:0];

  // Arithmetic shift kept in its own signed variable so the shift stays arithmetic.
  logic signed [31:0] sra_value;
  assign sra_value = $signed(rs1_value) >>> shamt;

  logic [31:0] alu_result;
  // RV32I integer ALU; SUB only exists in the register-register form.
  always_comb begin
    alu_result = '0;
    case (funct3)
      3'b000:  alu_result = (alt && !use_imm) ? rs1_value - operand_b : rs1_value + operand_b;
      3'b001:  alu_result = rs1_value << shamt;
      3'b010:  alu_result = {31'b0, $signed(rs1_value) < $signed(operand_b)};
      3'b011:  alu_result = {31'b0, rs1_value < operand_b};
      3'b100:  alu_result = rs1_value ^ operand_b;
      3'b101:  alu_result = alt ? sra_value : rs1_value >> shamt;
      3'b110:  alu_result = rs1_value | operand_b;
      default: alu_result = rs1_value & operand_b;
    endcase
  end

  // Multiplier: sign-extend each operand to 64 bits as the op requires; the low
  // 64 bits of the product are exact for every signedness combination.
  logic        mul_a_signed, mul_b_signed;
  logic [63:0] mul_a, mul_b, product;
  logic [31:0] mul_result;
  assign mul_a_signed = (funct3[1:0] != 2'b11) && rs1_value[31];
  assign mul_b_signed = (funct3[1:0] == 2'b01) && operand_b[31];
  assign mul_a        = {{32{mul_a_signed}}, rs1_value};
  assign mul_b        = {{32{mul_b_signed}}, operand_b};
  assign product      = mul_a * mul_b;
  assign mul_result   = (funct3[1:0] == 2'b00) ? product[31:0] : product[63:32];

  // Divide decode and the two cases that resolve without iterating.
  logic        is_div, div_signed, div_by_zero, div_overflow, div_special, start_div;
  logic        dividend_neg, divisor_neg;
  logic [31:0] dividend_abs, divisor_abs, special_result, exec_result;
  assign is_div         = m_ext && funct3[2];
  assign div_signed     = !funct3[0];
  assign div_by_zero    = (operand_b == 32'd0);
  assign div_overflow   = div_signed && (rs1_value == 32'h8000_0000) && (operand_b == 32'hFFFF_FFFF);
  assign div_special    = div_by_zero || div_overflow;
  assign dividend_neg   = div_signed && rs1_value[31];
  assign divisor_neg    = div_signed && operand_b[31];
  assign dividend_abs   = dividend_neg ? -rs1_value : rs1_value;
  assign divisor_abs    = divisor_neg ? -operand_b : operand_b;
  assign special_result = funct3[1] ? (div_by_zero ? rs1_value : 32'd0)
                                    : (div_by_zero ? 32'hFFFF_FFFF : 32'h8000_0000);
  assign exec_result    = !m_ext ? alu_result : (!funct3[2] ? mul_result : special_result);
  assign start_div      = (state == IDLE) && !stall_in && valid_in && is_div && !div_special;

  // Divider working registers, latched when the divide is accepted.
  logic [31:0] div_quot, div_rem, div_divisor;
  logic        neg_quot, neg_rem, op_rem, div_write_rd;
  logic [4:0]  div_rd, step;

  // One restoring step: shift in the next dividend bit, subtract if it fits.
  logic [32:0] rem_shift, rem_diff;
  logic        rem_fits, div_done;
  logic [31:0] next_rem, next_quot, final_quot, final_rem;
  assign rem_shift  = {div_rem, div_quot[31]};
  assign rem_diff   = rem_shift - {1'b0, div_divisor};
  assign rem_fits   = !rem_diff[32];
  assign next_rem   = rem_fits ? rem_diff[31:0] : rem_shift[31:0];
  assign next_quot  = {div_quot[30:0], rem_fits};
  assign final_quot = neg_quot ? -next_quot : next_quot;
  assign final_rem  = neg_rem ? -next_rem : next_rem;
  assign div_done   = (state == DIVIDE) && !stall_in && (step == 5'd31);

  assign stall_out = stall_in || (state == DIVIDE);

  // FSM state register.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // FSM next state: enter on a normal divide, leave when the last step completes.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_div) state_next = DIVIDE;
      default: if (div_done)  state_next = IDLE;
    endcase
  end

  // Divider datapath: latch magnitudes and signs on entry, iterate while not stalled.
  always_ff @(posedge clock) begin
    if (reset) begin
      div_quot     <= '0;
      div_rem      <= '0;
      div_divisor  <= '0;
      neg_quot     <= 1'b0;
      neg_rem      <= 1'b0;
      op_rem       <= 1'b0;
      div_rd       <= '0;
      div_write_rd <= 1'b0;
      step         <= '0;
    end else if (start_div) begin
      div_quot     <= dividend_abs;
      div_rem      <= '0;
      div_divisor  <= divisor_abs;
      neg_quot     <= dividend_neg ^ divisor_neg;
      neg_rem      <= dividend_neg;
      op_rem       <= funct3[1];
      div_rd       <= rd;
      div_write_rd <= write_rd;
      step         <= '0;
    end else if ((state == DIVIDE) && !stall_in) begin
      div_quot     <= next_quot;
      div_rem      <= next_rem;
      step         <= step + 5'd1;
    end
  end

  // Output registers: divider completion, single-cycle result, or a bubble on divide entry.
  always_ff @(posedge clock) begin
    if (reset) begin
      valid_out    <= 1'b0;
      result       <= '0;
      rd_out       <= '0;
      write_rd_out <= 1'b0;
    end else if (div_done) begin
      valid_out    <= 1'b1;
      result       <= op_rem ? final_rem : final_quot;
      rd_out       <= div_rd;
      write_rd_out <= div_write_rd;
    end else if (!stall_out) begin
      if (start_div) begin
        valid_out    <= 1'b0;
      end else begin
        valid_out    <= valid_in;
        result       <= exec_result;
        rd_out       <= rd;
        write_rd_out <= write_rd;
      end
    end
  end

endmodule

// File: tb/tb_execute_stage.sv
// Bench for execute_stage: directed vectors, expected results queued at issue time.
// A monitor pops the queue whenever a fresh result is presented and checks value and timing.
// Stall-duration, stall-hold and reset-abort behaviour are checked from the driver side.
module tb_execute_stage;

  logic        clock;
  logic        reset;
  logic        valid_in;
  logic        stall_in;
  logic [2:0]  funct3;
  logic        alt;
  logic        m_ext;
  logic        use_imm;
  logic [31:0] imm;
  logic [31:0] rs1_value;
  logic [31:0] rs2_value;
  logic [4:0]  rd;
  logic        write_rd;
  logic        stall_out;
  logic        valid_out;
  logic [31:0] result;
  logic [4:0]  rd_out;
  logic        write_rd_out;

  typedef struct {
    string       name;
    logic [31:0] res;
    logic [4:0]  rd;
    int          due;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   w;

  execute_stage dut (
    .clock(clock), .reset(reset), .valid_in(valid_in), .stall_in(stall_in),
    .funct3(funct3), .alt(alt), .m_ext(m_ext), .use_imm(use_imm), .imm(imm),
    .rs1_value(rs1_value), .rs2_value(rs2_value), .rd(rd), .write_rd(write_rd),
    .stall_out(stall_out), .valid_out(valid_out), .result(result), .rd_out(rd_out),
    .write_rd_out(write_rd_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a fresh result is one presented after an edge where the stage was not frozen.
  initial begin
    forever begin
      @(posedge clock);
      #1;
      if (valid_out && !stall_in && !reset) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_output: got result %h rd %0d, nothing expected", result, rd_out);
        end else begin
          mon_e = sb.pop_front();
          check({mon_e.name, " result"}, result, mon_e.res);
          check({mon_e.name, " rd_out"}, 32'(rd_out), 32'(mon_e.rd));
          check({mon_e.name, " write_rd_out"}, 32'(write_rd_out), 32'd1);
          check({mon_e.name, " cycle"}, cyc, mon_e.due);
        end
      end
    end
  end

  // Present one instruction, hold it while stall_out is high, then queue its expectation.
  task automatic issue(input string nm, input logic [2:0] f3, input logic a, input logic m,
                       input logic ui, input logic [31:0] im, input logic [31:0] r1,
                       input logic [31:0] r2, input logic [4:0] d, input logic [31:0] exp_res,
                       input int lat, input bit expect_out, output int waited);
    exp_t e;
    @(negedge clock);
    valid_in = 1'b1; funct3 = f3; alt = a; m_ext = m; use_imm = ui; imm = im;
    rs1_value = r1; rs2_value = r2; rd = d; write_rd = 1'b1;
    waited = 0;
    while (stall_out && waited < 100) begin
      @(negedge clock);
      waited++;
    end
    if (stall_out) begin
      checks++;
      errors++;
      $display("FAIL %s accept: stall_out still high after %0d cycles, required low", nm, waited);
    end else if (expect_out) begin
      e.name = nm; e.res = exp_res; e.rd = d; e.due = cyc + 1 + lat;
      sb.push_back(e);
    end
  endtask

  // Follow a divide in flight: count stall_out cycles, optionally inject stall_in or reset.
  task automatic run_divide(input int stall_at, input int abort_at, output int n);
    n = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clock);
      valid_in = 1'b0;
      if (!stall_out) break;
      n++;
      stall_in = (n >= stall_at) && (n < stall_at + 3);
      if (n == abort_at) begin
        reset = 1'b1;
        break;
      end
    end
    stall_in = 1'b0;
  endtask

  initial begin
    reset = 1'b1; valid_in = 1'b0; stall_in = 1'b0; funct3 = '0; alt = 1'b0; m_ext = 1'b0;
    use_imm = 1'b0; imm = '0; rs1_value = '0; rs2_value = '0; rd = '0; write_rd = 1'b0;
    repeat (3) @(negedge clock);
    check("reset valid_out", 32'(valid_out), 32'd0);
    check("reset result", result, 32'd0);
    check("reset rd_out", 32'(rd_out), 32'd0);
    check("reset write_rd_out", 32'(write_rd_out), 32'd0);
    check("reset stall_out", 32'(stall_out), 32'd0);
    reset = 1'b0;

    // Single-cycle ops, back to back.
    issue("ADD",    3'b000, 0, 0, 0, 32'h0,   32'd5,         32'hFFFF_FFF9, 5'd3,  32'hFFFF_FFFE, 0, 1, w);
    issue("SRAI",   3'b101, 1, 0, 1, 32'h404, 32'h8000_0000, 32'h0,         5'd4,  32'hF800_0000, 0, 1, w);
    issue("SLTU",   3'b011, 0, 0, 0, 32'h0,   32'd1,         32'hFFFF_FFFF, 5'd5,  32'd1,         0, 1, w);
    issue("MULHU",  3'b011, 0, 1, 0, 32'h0,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFE, 0, 1, w);
    issue("SUB",    3'b000, 1, 0, 0, 32'h0,   32'd10,        32'd3,         5'd7,  32'd7,         0, 1, w);
    issue("ADDI",   3'b000, 1, 0, 1, 32'd3,   32'd10,        32'd100,       5'd8,  32'd13,        0, 1, w);
    issue("SLT",    3'b010, 0, 0, 0, 32'h0,   32'hFFFF_FFFF, 32'd1,         5'd9,  32'd1,         0, 1, w);
    issue("SLL",    3'b001, 0, 0, 0, 32'h0,   32'd1,         32'h3F,        5'd10, 32'h8000_0000, 0, 1, w);
    issue("SRL",    3'b101, 0, 0, 0, 32'h0,   32'h8000_0000, 32'd4,         5'd11, 32'h0800_0000, 0, 1, w);
    issue("XOR",    3'b100, 0, 0, 0, 32'h0,   32'hF0F0_F0F0, 32'hFF00_FF00, 5'd12, 32'h0FF0_0FF0, 0, 1, w);
    issue("AND",    3'b111, 0, 0, 0, 32'h0,   32'hF0F0_F0F0, 32'hFF00_FF00, 5'd13, 32'hF000_F000, 0, 1, w);
    issue("MUL",    3'b000, 0, 1, 0, 32'h0,   32'hFFFF_FFFD, 32'd5,         5'd14, 32'hFFFF_FFF1, 0, 1, w);
    issue("MULH",   3'b001, 0, 1, 0, 32'h0,   32'h8000_0000, 32'h8000_0000, 5'd15, 32'h4000_0000, 0, 1, w);
    issue("MULHSU", 3'b010, 0, 1, 0, 32'h0,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd16, 32'hFFFF_FFFF, 0, 1, w);

    // DIV then REM held upstream: REM is accepted the edge after DIV completes.
    issue("DIV",    3'b100, 0, 1, 0, 32'h0,   32'hFFFF_FFEC, 32'd3,         5'd17, 32'hFFFF_FFFA, 32, 1, w);
    issue("REM",    3'b110, 0, 1, 0, 32'h0,   32'hFFFF_FFEC, 32'd3,         5'd18, 32'hFFFF_FFFE, 32, 1, w);
    check("DIV stall_out cycles", w, 32);
    issue("DIVU0",  3'b101, 0, 1, 0, 32'h0,   32'd7,         32'd0,         5'd19, 32'hFFFF_FFFF, 0, 1, w);
    check("REM stall_out cycles", w, 32);
    issue("REMOVF", 3'b110, 0, 1, 0, 32'h0,   32'h8000_0000, 32'hFFFF_FFFF, 5'd20, 32'd0,         0, 1, w);
    check("DIVU by zero stall_out cycles", w, 0);
    issue("DIVOVF", 3'b100, 0, 1, 0, 32'h0,   32'h8000_0000, 32'hFFFF_FFFF, 5'd21, 32'h8000_0000, 0, 1, w);
    check("REM overflow stall_out cycles", w, 0);

    // stall_in after a single-cycle result: output must hold and be reported once.
    issue("OR",     3'b110, 0, 0, 0, 32'h0,   32'hF0F0_F0F0, 32'hFF00_FF00, 5'd22, 32'hFFF0_FFF0, 0, 1, w);
    @(negedge clock);
    valid_in = 1'b0;
    stall_in = 1'b1;
    for (int k = 0; k < 2; k++) begin
      @(negedge clock);
      check("hold valid_out", 32'(valid_out), 32'd1);
      check("hold result", result, 32'hFFF0_FFF0);
    end
    stall_in = 1'b0;

    // Divide with three stall_in cycles injected mid-flight.
    issue("DIV100_7", 3'b100, 0, 1, 0, 32'h0, 32'd100, 32'd7, 5'd23, 32'd14, 35, 1, w);
    run_divide(10, 1000, w);
    check("stalled DIV stall_out cycles", w, 35);

    // Reset during a divide: everything cleared, nothing emitted afterwards.
    issue("DIVABORT", 3'b100, 0, 1, 0, 32'h0, 32'd1000, 32'd3, 5'd24, 32'd0, 0, 0, w);
    run_divide(1000, 10, w);
    @(negedge clock);
    check("abort valid_out", 32'(valid_out), 32'd0);
    check("abort result", result, 32'd0);
    check("abort rd_out", 32'(rd_out), 32'd0);
    check("abort write_rd_out", 32'(write_rd_out), 32'd0);
    check("abort stall_out", 32'(stall_out), 32'd0);
    reset = 1'b0;
    issue("ADD_AFTER", 3'b000, 0, 0, 0, 32'h0, 32'd1, 32'd2, 5'd1, 32'd3, 0, 1, w);
    check("ADD after abort wait", w, 0);
    @(negedge clock);
    valid_in = 1'b0;

    repeat (40) @(negedge clock);
    check("results outstanding", sb.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
